// File: rtl/uart_param_loader.sv
// rtl/uart_param_loader.sv - UART receiver and framed parameter loader for the photon stage
//
// Receives 8N1 bytes on rxd and parses 5-byte frames
//   0xAA, FW_HI, FW_LO, EFF, CHK   (CHK = FW_HI ^ FW_LO ^ EFF)
// A frame with a matching checksum and EFF <= 100 commits full_width and
// detect_efficiency together and pulses param_valid. Rejected bytes/frames and
// inter-byte timeouts pulse frame_err.
//
// Ports
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-high reset
//   rxd               in   asynchronous UART line, idle high
//   full_width        out  [15:0] committed photon pulse full width
//   detect_efficiency out  [7:0]  committed detection efficiency, percent
//   param_valid       out  one-cycle pulse when the outputs take new values
//   frame_err         out  one-cycle pulse on a rejected byte or frame
//   LED               out  [3:0] {rxd_sync, sticky_err, commit_toggle, in_frame}

module uart_param_loader #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 115_200,
    parameter logic [15:0] DEF_WIDTH = 16'd100,
    parameter logic [7:0]  DEF_EFF   = 8'd50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [15:0] full_width,
    output logic [7:0]  detect_efficiency,
    output logic        param_valid,
    output logic        frame_err,
    output logic [3:0]  LED
);

    localparam int CPB_RAW      = CLK_FREQ / BAUD;
    localparam int CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = 20 * CLKS_PER_BIT;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int TW           = $clog2(TIMEOUT_CLKS);

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [7:0] EFF_MAX   = 8'd100;

    // ------------------------------------------------------------------
    // rxd synchronizer; r_rx_prev gives the falling-edge detector its history
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_byte_ok;
    logic        r_stop_err;

    logic w_fall;
    logic w_half_tick;
    logic w_bit_tick;
    logic w_rx_sample;
    logic w_byte_done;
    logic w_stop_bad;

    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_half_tick = (r_clk_cnt == CW'(HALF_BIT - 1));
    assign w_bit_tick  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_rx_next = RX_START;
                end
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch
                if (w_half_tick) begin
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_bit_tick && (r_bit_idx == 3'd7)) begin
                    w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_bit_tick) begin
                    w_rx_next = RX_IDLE;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_sample = 1'b0;
        w_byte_done = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_rx_state)
            RX_DATA: w_rx_sample = w_bit_tick;
            RX_STOP: begin
                w_byte_done = w_bit_tick & r_rx_sync;
                w_stop_bad  = w_bit_tick & ~r_rx_sync;
            end
            default: begin
                w_rx_sample = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_byte     <= 8'd0;
            r_byte_ok  <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_byte_ok  <= w_byte_done;
            r_stop_err <= w_stop_bad;

            // Bit timer restarts on every state change so the first data
            // sample lands one full bit after the mid-start re-sample.
            if ((r_rx_state == RX_IDLE) || (w_rx_next != r_rx_state) || w_bit_tick) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + CW'(1);
            end

            if (r_rx_state == RX_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_rx_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // LSB arrives first, so shift in from the top
            if (w_rx_sample) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end

            if (w_byte_done) begin
                r_byte <= r_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_HUNT = 3'd0,
        P_FWH  = 3'd1,
        P_FWL  = 3'd2,
        P_EFF  = 3'd3,
        P_CHK  = 3'd4
    } p_state_t;

    p_state_t    r_p_state;
    p_state_t    w_p_next;
    logic [7:0]  r_fw_hi;
    logic [7:0]  r_fw_lo;
    logic [7:0]  r_eff;
    logic [TW-1:0] r_to_cnt;
    logic        r_led_toggle;
    logic        r_led_err;

    logic w_timeout;
    logic w_frame_ok;
    logic w_commit;
    logic w_chk_err;
    logic w_err;

    // A byte completing in the same cycle as the timeout expiry wins
    assign w_timeout  = (r_p_state != P_HUNT) && !r_byte_ok &&
                        (r_to_cnt == TW'(TIMEOUT_CLKS - 1));
    assign w_frame_ok = ((r_fw_hi ^ r_fw_lo ^ r_eff) == r_byte) && (r_eff <= EFF_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_state <= P_HUNT;
        end else begin
            r_p_state <= w_p_next;
        end
    end

    always_comb begin
        w_p_next = r_p_state;
        if (w_timeout) begin
            w_p_next = P_HUNT;
        end else if (r_byte_ok) begin
            case (r_p_state)
                // 0xAA only resynchronises from HUNT; elsewhere it is data
                P_HUNT:  w_p_next = (r_byte == SYNC_BYTE) ? P_FWH : P_HUNT;
                P_FWH:   w_p_next = P_FWL;
                P_FWL:   w_p_next = P_EFF;
                P_EFF:   w_p_next = P_CHK;
                P_CHK:   w_p_next = P_HUNT;
                default: w_p_next = P_HUNT;
            endcase
        end
    end

    always_comb begin
        w_commit  = 1'b0;
        w_chk_err = 1'b0;
        if ((r_p_state == P_CHK) && r_byte_ok) begin
            w_commit  = w_frame_ok;
            w_chk_err = ~w_frame_ok;
        end
        w_err = w_chk_err | w_timeout | r_stop_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fw_hi           <= 8'd0;
            r_fw_lo           <= 8'd0;
            r_eff             <= 8'd0;
            r_to_cnt          <= '0;
            full_width        <= DEF_WIDTH;
            detect_efficiency <= DEF_EFF;
            param_valid       <= 1'b0;
            frame_err         <= 1'b0;
            r_led_toggle      <= 1'b0;
            r_led_err         <= 1'b0;
        end else begin
            if (r_byte_ok) begin
                case (r_p_state)
                    P_FWH:   r_fw_hi <= r_byte;
                    P_FWL:   r_fw_lo <= r_byte;
                    P_EFF:   r_eff   <= r_byte;
                    default: r_eff   <= r_eff;
                endcase
            end

            if ((r_p_state == P_HUNT) || r_byte_ok || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            param_valid <= w_commit;
            frame_err   <= w_err & ~w_commit;

            if (w_commit) begin
                full_width        <= {r_fw_hi, r_fw_lo};
                detect_efficiency <= r_eff;
                r_led_toggle      <= ~r_led_toggle;
                r_led_err         <= 1'b0;
            end else if (w_err) begin
                r_led_err <= 1'b1;
            end
        end
    end

    assign LED = {r_rx_sync, r_led_err, r_led_toggle, (r_p_state != P_HUNT)};

endmodule

// File: tb/tb_uart_param_loader.sv
// tb/tb_uart_param_loader.sv - randomized self-checking bench for uart_param_loader

module tb_uart_param_loader;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] full_width;
    logic [7:0]  detect_efficiency;
    logic        param_valid;
    logic        frame_err;
    logic [3:0]  LED;

    uart_param_loader #(
        .CLK_FREQ (50_000_000),
        .BAUD     (5_000_000),
        .DEF_WIDTH(16'd100),
        .DEF_EFF  (8'd50)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rxd              (rxd),
        .full_width       (full_width),
        .detect_efficiency(detect_efficiency),
        .param_valid      (param_valid),
        .frame_err        (frame_err),
        .LED              (LED)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int pv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    // Reference state: what the outputs should hold after each transaction
    logic [15:0] m_fw   = 16'd100;
    logic [7:0]  m_eff  = 8'd50;
    logic        m_led1 = 1'b0;
    logic        m_led2 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (param_valid === 1'b1) pv_cnt++;
            if (frame_err === 1'b1) fe_cnt++;
            if ((param_valid === 1'b1) && (frame_err === 1'b1)) both_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = stop_bit;
        idle(CPB);
        rxd = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".fw"},  32'(full_width), 32'(m_fw));
        check_eq({tag, ".eff"}, 32'(detect_efficiency), 32'(m_eff));
        check_eq({tag, ".led"}, 32'(LED), 32'({1'b1, m_led2, m_led1, 1'b0}));
    endtask

    // Sends one complete frame and checks the result against the frame rules
    task automatic run_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] eff, input logic [7:0] chk, input int gap);
        int  pv0;
        int  fe0;
        bit  ok;
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(8'hAA, 1'b1); idle(gap);
        send_byte(hi, 1'b1);    idle(gap);
        send_byte(lo, 1'b1);    idle(gap);
        send_byte(eff, 1'b1);   idle(gap);
        send_byte(chk, 1'b1);
        idle(20);
        ok = ((hi ^ lo ^ eff) == chk) && (int'(eff) <= 100);
        if (ok) begin
            m_fw   = {hi, lo};
            m_eff  = eff;
            m_led1 = ~m_led1;
            m_led2 = 1'b0;
        end else begin
            m_led2 = 1'b1;
        end
        check_eq({tag, ".pv"}, 32'(pv_cnt - pv0), ok ? 32'd1 : 32'd0);
        check_eq({tag, ".fe"}, 32'(fe_cnt - fe0), ok ? 32'd0 : 32'd1);
        check_outputs(tag);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0;
        int fe0;
        logic [7:0] hi, lo, eff, chk, g;
        int gap;

        // Reset state while rst is held
        idle(3);
        check_eq("rst.fw",  32'(full_width), 32'd100);
        check_eq("rst.eff", 32'(detect_efficiency), 32'd50);
        check_eq("rst.led", 32'(LED), 32'h8);
        check_eq("rst.pv",  32'(param_valid), 32'd0);
        check_eq("rst.fe",  32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(30);
        check_eq("post_rst.pulses", 32'(pv_cnt + fe_cnt), 32'd0);

        // Directed frames
        run_frame("valid500", 8'h01, 8'hF4, 8'h32, 8'hC7, 0);
        run_frame("eff101",   8'h00, 8'h0A, 8'h65, 8'h6F, 3);
        run_frame("badchk",   8'h12, 8'h34, 8'h56, 8'h00, 0);
        run_frame("good1234", 8'h12, 8'h34, 8'h56, 8'h70, 5);
        run_frame("aa_data",  8'h00, 8'hAA, 8'h05, 8'hAF, 0);
        run_frame("eff100",   8'hAB, 8'hCD, 8'd100, 8'hAB ^ 8'hCD ^ 8'd100, 2);

        // Inter-byte timeout
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(5);
        check_eq("to.in_frame", 32'(LED[0]), 32'd1);
        idle(300);
        m_led2 = 1'b1;
        check_eq("to.fe", 32'(fe_cnt - fe0), 32'd1);
        check_eq("to.pv", 32'(pv_cnt - pv0), 32'd0);
        check_outputs("to");

        // Bad stop bit on a sync byte: discarded, so the following bytes are
        // hunted over and never form a frame
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(8'hAA, 1'b0);
        idle(20);
        check_eq("stop.fe", 32'(fe_cnt - fe0), 32'd1);
        check_eq("stop.hunt", 32'(LED[0]), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(20);
        check_eq("stop.pv", 32'(pv_cnt - pv0), 32'd0);
        check_outputs("stop");

        // Randomized frames with optional junk before the sync byte
        for (int k = 0; k < 10; k++) begin
            hi  = 8'($urandom);
            lo  = 8'($urandom);
            eff = 8'($urandom_range(0, 120));
            chk = hi ^ lo ^ eff;
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom);
                if (g == 8'hAA) g = 8'h55;
                send_byte(g, 1'b1);
            end
            gap = int'($urandom_range(0, 30));
            run_frame($sformatf("rnd%0d", k), hi, lo, eff, chk, gap);
        end

        // Reset in the middle of FW_LO
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        fork
            send_byte(8'hF4, 1'b1);
            begin
                idle(36);
                rst = 1'b1;
                idle(1);
                check_eq("midrst.fw",  32'(full_width), 32'd100);
                check_eq("midrst.eff", 32'(detect_efficiency), 32'd50);
                check_eq("midrst.led", 32'(LED), 32'h8);
                idle(1);
                rst = 1'b0;
            end
        join
        m_fw   = 16'd100;
        m_eff  = 8'd50;
        m_led1 = 1'b0;
        m_led2 = 1'b0;
        idle(300);
        check_eq("midrst.pv", 32'(pv_cnt - pv0), 32'd0);
        check_eq("midrst.fe", 32'(fe_cnt - fe0), 32'd0);
        check_outputs("midrst");
        run_frame("after_rst", 8'h01, 8'hF4, 8'h32, 8'hC7, 0);

        check_eq("pv_fe_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
